// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and width helpers for the branch predictor
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam int STAT_W = 16;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_width(input int entries, input int pc_w);
    return pc_w - $clog2(entries);
  endfunction

  localparam int BP_ENTRIES = 16;
  localparam int BP_PC_W    = 8;
  localparam int BP_IDX_W   = idx_width(BP_ENTRIES);
  localparam int BP_TAG_W   = tag_width(BP_ENTRIES, BP_PC_W);

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, decode training and statistics bundle
// Statistic signals exist only when BP_STATS_EN is defined.
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int PC_W = 8
);
  logic            enable;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_next_pc;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispredict;
`ifdef BP_STATS_EN
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_mispredicts;
`endif

  modport master (
    output enable, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
`ifdef BP_STATS_EN
    input  stat_hits, stat_mispredicts,
`endif
    input  pred_hit, pred_taken, pred_next_pc
  );

  modport slave (
    input  enable, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
`ifdef BP_STATS_EN
    output stat_hits, stat_mispredicts,
`endif
    output pred_hit, pred_taken, pred_next_pc
  );

endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating direction counter next-state logic
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken && (i_ctr != CTR_ST)) begin
      o_ctr = i_ctr + 2'd1;
    end else if (!i_taken && (i_ctr != CTR_SNT)) begin
      o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, trained from decode
// Optional BP_STATS_EN adds saturating hit/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 8
)(
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(ENTRIES, PC_W);

  // Register array rather than a memory: lookup must be an asynchronous read.
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_u_ctr_next;
  logic             w_upd_en;

  assign w_f_idx = bp.fetch_pc[IDX_W-1:0];
  assign w_f_tag = bp.fetch_pc[PC_W-1:IDX_W];
  assign w_u_idx = bp.upd_pc[IDX_W-1:0];
  assign w_u_tag = bp.upd_pc[PC_W-1:IDX_W];

  assign bp.pred_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign bp.pred_taken   = bp.pred_hit && r_ctr[w_f_idx][1];
  assign bp.pred_next_pc = bp.pred_taken ? r_target[w_f_idx] : bp.fetch_pc + PC_W'(1);

  assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_upd_en = bp.enable && bp.upd_valid;

  sat_counter2 u_sat_counter2 (
    .i_ctr   (r_ctr[w_u_idx]),
    .i_taken (bp.upd_taken),
    .o_ctr   (w_u_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_ctr[i]    <= CTR_RESET;
        r_target[i] <= '0;
      end
    end else if (w_upd_en) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_next;
        if (bp.upd_taken) begin
          r_target[w_u_idx] <= bp.upd_target;
        end
      end else if (bp.upd_taken) begin
        // Taken miss evicts whatever lived at this index.
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_ctr[w_u_idx]    <= CTR_ALLOC;
        r_target[w_u_idx] <= bp.upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [STAT_W-1:0] r_stat_hits;
  logic [STAT_W-1:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_hits        <= '0;
      r_stat_mispredicts <= '0;
    end else if (bp.enable) begin
      if (bp.pred_hit && (r_stat_hits != '1)) begin
        r_stat_hits <= r_stat_hits + STAT_W'(1);
      end
      if (bp.upd_valid && bp.upd_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
      end
    end
  end

  assign bp.stat_hits        = r_stat_hits;
  assign bp.stat_mispredicts = r_stat_mispredicts;
`else
  logic w_unused_mispredict;
  assign w_unused_mispredict = bp.upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - vector table with expected-result queue, plus reset and statistics sequences
module tb_branch_predictor;

  logic clk;
  logic rst;

  branch_predictor_if #(.PC_W(8)) bp_if ();

  branch_predictor #(.ENTRIES(16), .PC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] fpc;
    logic       uv;
    logic [7:0] upc;
    logic       ut;
    logic [7:0] utgt;
    logic       ehit;
    logic       etaken;
    logic [7:0] enext;
  } vec_t;

  typedef struct {
    logic       hit;
    logic       taken;
    logic [7:0] next;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r, logic e, logic [7:0] f, logic uv, logic [7:0] up,
                              logic ut, logic [7:0] tg, logic h, logic tk, logic [7:0] nx);
    vec_t v;
    v.rst_n = r; v.en = e; v.fpc = f; v.uv = uv; v.upc = up; v.ut = ut; v.utgt = tg;
    v.ehit = h; v.etaken = tk; v.enext = nx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic [7:0] f, input logic uv,
                        input logic [7:0] up, input logic ut, input logic [7:0] tg, input logic mis);
    rst                  = r;
    bp_if.enable         = e;
    bp_if.fetch_pc       = f;
    bp_if.upd_valid      = uv;
    bp_if.upd_pc         = up;
    bp_if.upd_taken      = ut;
    bp_if.upd_target     = tg;
    bp_if.upd_mispredict = mis;
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] f, input logic uv,
                      input logic [7:0] up, input logic ut, input logic [7:0] tg, input logic mis);
    @(negedge clk);
    set_in(r, e, f, uv, up, ut, tg, mis);
  endtask

  initial begin
    exp_t e;
    set_in(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // rst, en, fetch, uv, upc, ut, tgt, exp hit, exp taken, exp next
    vecs.push_back(mk(1, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0, 0, 8'h06));
    vecs.push_back(mk(1, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h40, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h23, 0, 8'h00, 0, 8'h00, 0, 0, 8'h24));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 0, 8'h00, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 0, 8'h00, 1, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h40, 1, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h40, 1, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h40, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h40, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 0, 8'h00, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h50, 1, 1, 8'h40));
    vecs.push_back(mk(1, 0, 8'h13, 1, 8'h13, 1, 8'h60, 1, 1, 8'h50));
    vecs.push_back(mk(1, 0, 8'h13, 1, 8'h13, 0, 8'h00, 1, 1, 8'h50));
    vecs.push_back(mk(1, 0, 8'h13, 1, 8'h13, 0, 8'h00, 1, 1, 8'h50));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 0, 8'h00, 1, 1, 8'h50));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 1, 1, 8'h50));
    vecs.push_back(mk(0, 1, 8'h13, 1, 8'h13, 1, 8'h70, 1, 1, 8'h50));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 0, 8'h00, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h23, 1, 8'h23, 1, 8'h7F, 0, 0, 8'h24));
    vecs.push_back(mk(1, 1, 8'h23, 0, 8'h00, 0, 8'h00, 1, 1, 8'h7F));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h13, 1, 8'h33, 0, 0, 8'h14));
    vecs.push_back(mk(1, 1, 8'h23, 0, 8'h00, 0, 8'h00, 0, 0, 8'h24));
    vecs.push_back(mk(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 1, 1, 8'h33));
    vecs.push_back(mk(1, 1, 8'hFF, 1, 8'hFF, 1, 8'h11, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_in(vecs[i].rst_n, vecs[i].en, vecs[i].fpc, vecs[i].uv, vecs[i].upc,
             vecs[i].ut, vecs[i].utgt, 1'b0);
      exp_q.push_back('{hit: vecs[i].ehit, taken: vecs[i].etaken, next: vecs[i].enext});
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_hit", i),   {15'd0, bp_if.pred_hit},   {15'd0, e.hit});
      chk($sformatf("v%0d_taken", i), {15'd0, bp_if.pred_taken}, {15'd0, e.taken});
      chk($sformatf("v%0d_next", i),  {8'd0, bp_if.pred_next_pc}, {8'd0, e.next});
    end

`ifdef BP_STATS_EN
    step(0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0);
    step(0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h05, 0, 8'h00, 0, 8'h00, 0);
    #2;
    chk("stat_hits_reset", bp_if.stat_hits, 16'h0000);
    chk("stat_mis_reset", bp_if.stat_mispredicts, 16'h0000);
    step(1, 1, 8'h05, 1, 8'h13, 1, 8'h40, 0);
    repeat (3) step(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h13, 1, 8'h23, 0, 8'h00, 1);
    repeat (2) step(1, 1, 8'h05, 1, 8'h23, 0, 8'h00, 1);
    step(1, 1, 8'h05, 0, 8'h00, 0, 8'h00, 1);
    step(1, 0, 8'h05, 0, 8'h00, 0, 8'h00, 0);
    #2;
    chk("stat_hits_3", bp_if.stat_hits, 16'd3);
    chk("stat_mis_2", bp_if.stat_mispredicts, 16'd2);

    step(0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0);
    step(1, 1, 8'h05, 1, 8'h13, 1, 8'h40, 0);
    repeat (65534) step(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    #2;
    chk("stat_hits_fffe", bp_if.stat_hits, 16'hFFFE);
    step(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    #2;
    chk("stat_hits_ffff", bp_if.stat_hits, 16'hFFFF);
    step(1, 1, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 8'h13, 0, 8'h00, 0, 8'h00, 0);
    #2;
    chk("stat_hits_sat", bp_if.stat_hits, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor for the 8-bit-PC pipelined core: a direct-mapped branch target buffer with 2-bit saturating direction counters. It sits upstream of the IF/ID register, looks up the current fetch PC combinationally and supplies the predicted next PC to the PC mux. It is trained by the decode stage, which resolves branches and jumps one cycle later.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 2..64
- PC_W, 8, PC width; the index is the low log2(ENTRIES) bits, the tag is the remaining PC_W-log2(ENTRIES) bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (clears state on a clk edge while low)
- enable  in  1  pipeline advance, the same signal the pipe registers use; 0 freezes all state
- fetch_pc  in  PC_W  PC being fetched this cycle
- pred_hit  out  1  fetch_pc matches a valid entry
- pred_taken  out  1  pred_hit AND counter MSB set
- pred_next_pc  out  PC_W  entry target if pred_taken, else fetch_pc+1 (modulo 2^PC_W)
- upd_valid  in  1  decode has resolved a branch or jump this cycle
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_taken  in  1  actual direction; jumps drive 1
- upd_target  in  PC_W  actual target
- upd_mispredict  in  1  decode detected a prediction error; used only by statistics
- stat_hits  out  16  lookup hits (BP_STATS_EN only)
- stat_mispredicts  out  16  mispredicts (BP_STATS_EN only)

## Operation
- Each entry holds valid, tag, a 2-bit counter and a PC_W target. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from fetch_pc and current table contents.
- Update is applied at a clk edge when rst=1, enable=1 and upd_valid=1. The entry is selected by the upd_pc index:
  - Hit (valid and tag equal), taken: counter saturating +1 (11 stays 11), target := upd_target.
  - Hit, not taken: counter saturating -1 (00 stays 00), target unchanged.
  - Miss, taken: allocate. valid:=1, tag:=upd_pc tag, counter:=10, target:=upd_target. Any previous occupant is evicted.
  - Miss, not taken: no change.
- enable=0: no update and no statistic change, even if upd_valid=1. This prevents double training while decode is stalled.

## Timing
- Prediction latency is 0 cycles: pred_* follow fetch_pc within the same cycle.
- Update latency is 1 cycle: the new entry contents are visible to lookup starting the cycle after the update edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- Reset: every valid:=0, counter:=01, target:=0, and statistics := 0. While the table is empty after reset, pred_hit=0, pred_taken=0 and pred_next_pc=fetch_pc+1.
- Reset and update in the same cycle: reset wins.
- Reset mid-training: all learned state is discarded. The first subsequent update allocates from empty.
- fetch_pc = 2^PC_W-1 not predicted: pred_next_pc = 0 (wraps).

## Configuration
- BP_STATS_EN defined: stat_hits and stat_mispredicts exist. Each is a 16-bit counter that saturates at 16'hFFFF.
  - stat_hits increments on each enabled cycle with pred_hit=1.
  - stat_mispredicts increments on each enabled cycle with upd_valid=1 and upd_mispredict=1.
  - Both clear on reset.
- BP_STATS_EN undefined: the stat ports and their logic are absent. upd_mispredict is unused.

## Structure
- Shared package bp_pkg holds:
  - counter encoding constants: CTR_SNT, CTR_WNT, CTR_WT, CTR_ST
  - the counter reset value CTR_RESET=01 and the allocate value CTR_ALLOC=10
  - index-width and tag-width helper constants derived from ENTRIES and PC_W
  - the 16-bit statistic width
- One sub-module: sat_counter2. It takes the current 2-bit value and the direction and returns the next saturated value (combinational). It is instantiated once, on the update path.
- The table is a register array, not a memory macro, because it needs an asynchronous read.

## Test plan
- Reset, then fetch_pc=8'h05 → pred_hit=0, pred_taken=0, pred_next_pc=8'h06. fetch_pc=8'hFF → pred_next_pc=8'h00.
- Update upd_pc=8'h13, taken, target=8'h40. Next cycle fetch_pc=8'h13 → hit, taken, next_pc=8'h40. fetch_pc=8'h23 (same index, tag differs) → miss, next_pc=8'h24.
- Counter walk at 8'h13: two not-taken updates → counter 10→01→00, pred_taken=0, hit=1. Four taken updates → 01,10,11,11 (saturates).
- Same-cycle lookup and update on 8'h13 (taken, target 8'h50) → this cycle's next_pc is the old target 8'h40; the following cycle it is 8'h50. The same update with enable=0 → no change.
- Update together with rst=0 → the table is empty afterwards, hit=0. Not-taken update on a miss → no allocation, hit stays 0.
- With BP_STATS_EN: 3 enabled hit cycles and 2 mispredict updates → stat_hits=3, stat_mispredicts=2. Preload stat_hits to FFFF via 65535 hit cycles, then one more hit → stays FFFF.
